fractcam_rule_loader: RTL

Read-modify-write front end for the FracTCAM write port. The FracTCAM writes rules only as aligned 8-row groups, so this block accepts single-rule updates (address, data, keep). For each update it reads back the 7 sibling rows of the target group through the TCAM read port, merges in the new rule, and issues one 8-rule group write. It sits between the control plane (rule-update CSR or host mailbox) and the TCAM's `wr_*` / `rd_cmd_*` / `rd_rsp_*` ports.

---
 rtl/fractcam_rule_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fractcam_rule_loader.sv
// Read-modify-write loader for the FracTCAM group write port.
// Each single-rule update reads back its 7 sibling rows, merges the new rule and issues one 8-row write.
module fractcam_rule_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH-1:0]   req_keep,
  input  logic                    req_valid,
  output logic                    req_ready,

  output logic [ADDR_WIDTH-1:0]   resp_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,

  output logic [ADDR_WIDTH-1:0]   m_wr_addr,
  output logic [DATA_WIDTH*8-1:0] m_wr_data,
  output logic [DATA_WIDTH*8-1:0] m_wr_keep,
  output logic                    m_wr_valid,
  input  logic                    m_wr_ready,

  output logic [ADDR_WIDTH-1:0]   m_rd_cmd_addr,
  output logic                    m_rd_cmd_valid,
  input  logic                    m_rd_cmd_ready,

  input  logic [DATA_WIDTH-1:0]   m_rd_rsp_data,
  input  logic [DATA_WIDTH-1:0]   m_rd_rsp_keep,
  input  logic                    m_rd_rsp_valid,
  output logic                    m_rd_rsp_ready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_RSP,
    WRITE,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            lane_q, lane_d;
  logic [2:0]            remain_q, remain_d;
  logic [DATA_WIDTH-1:0] lane_data_q [8];
  logic [DATA_WIDTH-1:0] lane_data_d [8];
  logic [DATA_WIDTH-1:0] lane_keep_q [8];
  logic [DATA_WIDTH-1:0] lane_keep_d [8];
  logic [2:0]            next_lane;

  // The target lane already holds the request, so the walk steps over it.
  always_comb begin
    next_lane = lane_q + 3'd1;
    if (next_lane == addr_q[2:0]) begin
      next_lane = lane_q + 3'd2;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    remain_d    = remain_q;
    lane_data_d = lane_data_q;
    lane_keep_d = lane_keep_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d                       = req_addr;
          lane_data_d[req_addr[2:0]]   = req_data;
          lane_keep_d[req_addr[2:0]]   = req_keep;
          lane_d                       = (req_addr[2:0] == 3'd0) ? 3'd1 : 3'd0;
          remain_d                     = 3'd7;
          state_d                      = RD_CMD;
        end
      end
      RD_CMD: begin
        if (m_rd_cmd_ready) begin
          state_d = RD_RSP;
        end
      end
      RD_RSP: begin
        if (m_rd_rsp_valid) begin
          lane_data_d[lane_q] = m_rd_rsp_data;
          lane_keep_d[lane_q] = m_rd_rsp_keep;
          lane_d              = next_lane;
          remain_d            = remain_q - 3'd1;
          // Exit is decided by the remaining count, never by lane wrap-around.
          state_d             = (remain_q == 3'd1) ? WRITE : RD_CMD;
        end
      end
      WRITE: begin
        if (m_wr_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      lane_q   <= '0;
      remain_q <= '0;
      for (int i = 0; i < 8; i++) begin
        lane_data_q[i] <= '0;
        lane_keep_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      remain_q    <= remain_d;
      lane_data_q <= lane_data_d;
      lane_keep_q <= lane_keep_d;
    end
  end

  // Every output is a register or a decode of the state register.
  assign req_ready      = (state_q == IDLE);
  assign m_rd_cmd_valid = (state_q == RD_CMD);
  assign m_rd_rsp_ready = (state_q == RD_RSP);
  assign m_wr_valid     = (state_q == WRITE);
  assign resp_valid     = (state_q == RESP);

  assign resp_addr      = addr_q;
  assign m_wr_addr      = {addr_q[ADDR_WIDTH-1:3], 3'b000};
  assign m_rd_cmd_addr  = {addr_q[ADDR_WIDTH-1:3], lane_q};

  for (genvar g = 0; g < 8; g++) begin : g_pack
    assign m_wr_data[g*DATA_WIDTH +: DATA_WIDTH] = lane_data_q[g];
    assign m_wr_keep[g*DATA_WIDTH +: DATA_WIDTH] = lane_keep_q[g];
  end

endmodule
